// File: rtl/alu_pipe.sv
// Two-stage pipelined RV32-style integer ALU with valid/ready handshakes on both sides.
// Define ALU_PIPE_SERIAL_SHIFT_EN to run sll/srl/sra one bit per cycle in stage S2.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_i_s_instr_types,
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    // Stage S1: registered operands and controls
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [2:0]       s1_f3_q;
    logic             s1_alt_q, s1_dec_q;

    // Stage S2: result register
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             s2_free, s1_adv, in_fire;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign shamt    = s1_b_q[SHW-1:0];

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_f3_q    <= 3'b000;
            s1_alt_q   <= 1'b0;
            s1_dec_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_a_q   <= a_in;
                s1_b_q   <= b_in;
                s1_f3_q  <= funct3;
                s1_alt_q <= alt;
                s1_dec_q <= r_i_s_instr_types;
            end
        end
    end

    always_comb begin
        alu_res = s1_a_q + s1_b_q;
        if (s1_dec_q) begin
            unique case (s1_f3_q)
                3'b000: alu_res = s1_alt_q ? (s1_a_q - s1_b_q) : (s1_a_q + s1_b_q);
                3'b001: alu_res = s1_a_q << shamt;
                3'b010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
                3'b011: alu_res = {{(WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
                3'b100: alu_res = s1_a_q ^ s1_b_q;
                3'b101: alu_res = s1_alt_q ? $unsigned($signed(s1_a_q) >>> shamt)
                                           : (s1_a_q >> shamt);
                3'b110: alu_res = s1_a_q | s1_b_q;
                3'b111: alu_res = s1_a_q & s1_b_q;
                default: alu_res = s1_a_q + s1_b_q;
            endcase
        end
    end

`ifdef ALU_PIPE_SERIAL_SHIFT_EN
    typedef enum logic {StIdle, StShift} state_e;
    state_e         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           sh_left_q, sh_left_d, sh_arith_q, sh_arith_d;
    logic           is_shift, start_shift;

    assign is_shift    = s1_dec_q && ((s1_f3_q == 3'b001) || (s1_f3_q == 3'b101));
    assign start_shift = s1_adv && is_shift && (shamt != '0);
    // S2 is busy for the whole serial shift, which stalls S1 behind it
    assign s2_free     = (state_q == StIdle) && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_shift) state_d = StShift;
            StShift: if (cnt_q == SHW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        sh_left_d   = sh_left_q;
        sh_arith_d  = sh_arith_q;
        unique case (state_q)
            StIdle: begin
                if (start_shift) begin
                    out_d       = s1_a_q;
                    out_valid_d = 1'b0;
                    cnt_d       = shamt;
                    sh_left_d   = (s1_f3_q == 3'b001);
                    sh_arith_d  = s1_alt_q;
                end else if (s1_adv) begin
                    out_d       = alu_res;
                    out_valid_d = 1'b1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            StShift: begin
                out_d = sh_left_q ? (out_q << 1)
                                  : {sh_arith_q & out_q[WIDTH-1], out_q[WIDTH-1:1]};
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            sh_left_q  <= 1'b0;
            sh_arith_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sh_left_q  <= sh_left_d;
            sh_arith_q <= sh_arith_d;
        end
    end
`else
    assign s2_free = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (s1_adv) begin
            out_d       = alu_res;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; SHALL NOT be overridden.
REQ-003 Port clk  input  1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port r_i_s_instr_types  input  1: high = decode funct3/alt; low = force add.
REQ-006 Port funct3  input  3: operation select.
REQ-007 Port alt  input  1: funct7[5]; selects sub (funct3=000, R-type only) and sra (funct3=101).
REQ-008 Port a_in, b_in  input  WIDTH: operands.
REQ-009 Port in_valid  input  1 / in_ready  output  1: input handshake; transfer when both high.
REQ-010 Port out  output  WIDTH: result.
REQ-011 Port out_valid  output  1 / out_ready  input  1: output handshake; transfer when both high.

Function
REQ-012 Ops with r_i_s_instr_types=1: 000 add, or sub if alt; 001 sll; 010 slt (signed, result 1/0); 011 sltu; 100 xor; 101 srl, or sra if alt; 110 or; 111 and.
REQ-013 Shift amount = b_in[SHW-1:0]; upper b_in bits ignored.
REQ-014 Add/sub wrap modulo 2^WIDTH; no carry or overflow output.
REQ-015 Stage S1 registers operands and controls on an input transfer; stage S2 holds out/out_valid.
REQ-016 No backpressure: result visible on out with out_valid high exactly 2 cycles after the input-transfer edge.
REQ-017 S2 accepts from S1 when out_valid=0 or out_ready=1 (and, with REQ-026, S2 is IDLE).
REQ-018 in_ready = S1 empty OR S1 advancing this cycle; combinational from out_ready.
REQ-019 Full throughput: one transfer per cycle when out_ready is held high.
REQ-020 out and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous S2 output transfer, S1->S2 move and new input transfer in one cycle SHALL lose no data and duplicate no result.
REQ-022 Results leave in input order; inputs with in_valid=0 never produce output.

Reset
REQ-023 On rst: out=0, out_valid=0, S1 empty, FSM IDLE, shift counter 0; in_ready=1 from the first cycle after release.
REQ-024 Reset asserted mid-operation (including during a serial shift) SHALL discard all in-flight operations; none emerge after release.

Configuration
REQ-025 Macro ALU_PIPE_SERIAL_SHIFT_EN undefined: all shifts combinational in S1->S2, latency per REQ-016.
REQ-026 Macro ALU_PIPE_SERIAL_SHIFT_EN defined: sll/srl/sra execute in S2 one bit per cycle; FSM states IDLE, SHIFT.
REQ-027 IDLE->SHIFT when a shift op with shamt>0 moves into S2; counter loaded with shamt; out_valid=0 during SHIFT.
REQ-028 SHIFT: shift one position per cycle, decrement counter; on counter reaching 0, out_valid=1 and return to IDLE; latency = 2+shamt.
REQ-029 Shift with shamt=0 and non-shift ops bypass SHIFT; latency 2.
REQ-030 During SHIFT S1 stalls; in_ready=0 if S1 is full.
REQ-031 Results SHALL be bit-identical with and without the macro.

Verification
REQ-032 WIDTH=32, add a=0xFFFFFFFF, b=1, out_ready=1 -> out=0x00000000, out_valid 2 cycles after transfer.
REQ-033 funct3=101, alt=1, a=0x80000000, b=0x24 (shamt 4) -> out=0xF8000000; with macro, latency 6.
REQ-034 slt a=0xFFFFFFFF, b=1 -> 1; sltu same operands -> 0; r_i_s_instr_types=0 with funct3=111 -> a+b.
REQ-035 Stream of 8 back-to-back adds, out_ready low for 3 cycles mid-stream -> 8 results in order, out stable while stalled, in_ready low when both stages full.
REQ-036 rst pulsed during a serial shift (macro defined), shamt=20 -> out_valid=0, out=0 after reset; next op completes normally.
REQ-037 WIDTH=8, sll a=0x01, b=0xFF (shamt 7) -> out=0x80.
